memcpy_engine: RTL and testbench
================================

Name: memcpy_engine

Overview:
- Parametrised cache-line copy engine, successor to the single-line stop-and-wait AFU copier.
- Keeps up to MAX_OUTSTANDING reads in flight and tags each with its line index.
- Accepts out-of-order read responses into a tag-indexed line buffer, issues writes strictly in order, and counts write acks to completion.
- Sits between the AFU CSR/MMIO block (start, addresses, length) and the CCI-P/MPF request channels (flattened ports).

Parameters:
ADDR_W, 42, cache-line address width (byte address >> 6)
DATA_W, 512, line width
LEN_W, 20, width of line count
MAX_OUTSTANDING, 16, read slots and line buffer depth; power of 2, >= 2; TAG_W = log2(MAX_OUTSTANDING)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; sampled only in IDLE
src_addr  in  ADDR_W  first source line address
dst_addr  in  ADDR_W  first destination line address
num_lines  in  LEN_W  lines to copy
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse on completion
error  out  1  sticky; cleared only by accepted start or reset
lines_copied  out  LEN_W  write acks received in current job
rd_req_valid  out  1  read request
rd_req_addr  out  ADDR_W  read line address
rd_req_tag  out  TAG_W  slot tag (goes into mdata)
rd_almfull  in  1  read channel almost-full
rd_rsp_valid  in  1  read response
rd_rsp_tag  in  TAG_W  response tag
rd_rsp_data  in  DATA_W  response data
wr_req_valid  out  1  write request
wr_req_addr  out  ADDR_W  write line address
wr_req_data  out  DATA_W  write data
wr_almfull  in  1  write channel almost-full
wr_rsp_valid  in  1  write response
wr_rsp_count  in  3  lines acked by this response (1..4; packed acks)

Behaviour:
- All outputs registered. Reset values: all valids, busy, done, error = 0; lines_copied = 0; addr/data/tag = 0; FSM = IDLE; all slot-valid bits = 0.
- FSM states:
  - IDLE: start with num_lines > 0 -> RUN. Latches src, dst and num_lines; clears counters and error.
  - IDLE: start with num_lines == 0 -> DONE. No requests issued.
  - RUN: writes_issued == num_lines -> DRAIN.
  - DRAIN: acks == num_lines -> DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE.
- busy = 1 in RUN and DRAIN. start outside IDLE is ignored.
- Counters rd_issued, wr_issued and acks are LEN_W+1 bits wide.
- Read issue:
  - Issue condition: RUN, rd_issued < num_lines, (rd_issued - wr_issued) < MAX_OUTSTANDING, and rd_almfull low in the current cycle.
  - On issue, the next cycle drives rd_req_valid = 1, rd_req_addr = src + rd_issued, rd_req_tag = rd_issued[TAG_W-1:0].
  - At most one read per cycle; back-to-back issue is allowed.
  - First read is visible 2 cycles after the start pulse (latch cycle, then issue register).
- Read response:
  - Writes rd_rsp_data into buffer[rd_rsp_tag] and sets valid[tag].
  - A response to a slot that is not outstanding, or whose valid bit is already set, sets error and is dropped.
- Write issue:
  - Issue condition: valid[wr_issued[TAG_W-1:0]] set and wr_almfull low.
  - On issue, the next cycle drives wr_req_valid = 1, wr_req_addr = dst + wr_issued, and wr_req_data = buffer entry; the slot's valid bit clears in the same edge.
  - Data that arrives in cycle T can be written no earlier than T+1. No same-cycle bypass.
- Read issue, read response and write issue may all occur in the same cycle. A slot freed by a write issue may be reused by a read issue in the next cycle, not the same cycle.
- Write ack: acks += wr_rsp_count and lines_copied mirrors acks. Acks pushing the total beyond num_lines set error and saturate at num_lines.
- Address arithmetic wraps modulo 2^ADDR_W. No error is raised on wrap.
- Order guarantee: write k is always issued before write k+1, whatever order the reads return.
- Reset mid-operation: returns to IDLE immediately; in-flight responses arriving afterwards in IDLE are ignored and do not set error.
- Responses in IDLE or DONE are ignored.

Decomposition:
- Package memcpy_pkg holds:
  - t_mc_state enum {IDLE, RUN, DRAIN, DONE}
  - t_line_addr / t_line_data typedefs
  - localparam for the ack width (3)
- Sub-module memcpy_slot_buf: MAX_OUTSTANDING x DATA_W register/RAM buffer.
  - Valid bit per slot; one write port (response) and one read port (write issue).
  - Registered read; set/clear on distinct or same slots in the same cycle.

Test Plan:
- num_lines=1, src=0x100, dst=0x200, response after 5 cycles -> one read (addr 0x100, tag 0), one write (addr 0x200) with the same data; done after the ack; lines_copied=1.
- num_lines=40, MAX_OUTSTANDING=16, responses withheld -> exactly 16 reads issued, tags 0..15; releasing tag 0 allows exactly one further read (tag 0, addr src+16).
- num_lines=8, responses returned in tag order 7..0 -> no writes until tag 0 arrives, then writes dst..dst+7 in order with correct data.
- rd_almfull held high for 10 cycles mid-job, then wr_almfull for 10 -> no request issued while the respective signal is high; completion unaffected; the data pattern matches.
- num_lines=4, acks as counts 3 then 1 -> DRAIN exits on the second ack; done pulses once; error=0. A duplicate response to tag 2 in a separate run -> error=1.
- num_lines=0 -> done 2 cycles after start, no requests. Reset asserted mid-job of 20 lines -> busy=0 next cycle; late responses are ignored.

Source files
------------

// File: rtl/memcpy_pkg.sv
// memcpy_pkg
//   Shared types and constants for the cache-line copy engine.
//   - t_mc_state   : job FSM states
//   - t_line_addr  : cache-line address (byte address >> 6)
//   - t_line_data  : one cache line of data
//   - MC_ACK_W     : width of the packed write-ack count
package memcpy_pkg;

  localparam int MC_ADDR_W = 42;
  localparam int MC_DATA_W = 512;
  localparam int MC_LEN_W  = 20;
  localparam int MC_ACK_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_mc_state;

  typedef logic [MC_ADDR_W-1:0] t_line_addr;
  typedef logic [MC_DATA_W-1:0] t_line_data;

endpackage

// File: rtl/memcpy_slot_buf.sv
// memcpy_slot_buf
//   Tag-indexed line buffer holding read responses until they can be
//   written back in order.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     flush             : clear every valid bit (new job)
//     set_en/idx/data   : store a response line and mark the slot valid
//     clr_en/idx        : consume a slot: clear its valid bit and load
//                         its data into the registered read port
//     valid             : per-slot valid bits
//     rd_data           : registered read data of the last consumed slot
module memcpy_slot_buf
  import memcpy_pkg::*;
#(
  parameter int SLOTS  = 16,
  parameter int DATA_W = MC_DATA_W,
  parameter int TAG_W  = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              set_en,
  input  logic [TAG_W-1:0]  set_idx,
  input  logic [DATA_W-1:0] set_data,
  input  logic              clr_en,
  input  logic [TAG_W-1:0]  clr_idx,
  output logic [SLOTS-1:0]  valid,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [SLOTS];

  // Line storage; contents are only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (set_en) begin
      mem[set_idx] <= set_data;
    end
  end

  // Valid bits; a set and a clear in the same cycle may target any slots,
  // a set wins if both hit the same slot.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= '0;
    end else begin
      if (clr_en) begin
        valid[clr_idx] <= 1'b0;
      end
      if (set_en) begin
        valid[set_idx] <= 1'b1;
      end
    end
  end

  // Registered read port: data leaves the buffer on the consuming edge,
  // so a line stored this cycle can never be bypassed to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (clr_en) begin
      rd_data <= mem[clr_idx];
    end
  end

endmodule

// File: rtl/memcpy_engine.sv
// memcpy_engine
//   Multi-outstanding cache-line copy engine. Issues up to MAX_OUTSTANDING
//   tagged reads, collects out-of-order responses in a slot buffer, issues
//   writes strictly in line order and counts (packed) write acks.
//   Ports:
//     clk, reset                    : clock, synchronous active-high reset
//     start/src_addr/dst_addr/num_lines : job request (sampled in IDLE)
//     busy/done/error/lines_copied  : job status (all registered)
//     rd_req_* / rd_almfull         : read request channel
//     rd_rsp_*                      : read response channel
//     wr_req_* / wr_almfull         : write request channel
//     wr_rsp_valid/wr_rsp_count     : write ack channel
module memcpy_engine
  import memcpy_pkg::*;
#(
  parameter  int ADDR_W          = MC_ADDR_W,
  parameter  int DATA_W          = MC_DATA_W,
  parameter  int LEN_W           = MC_LEN_W,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    num_lines,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_W-1:0]    lines_copied,
  output logic                rd_req_valid,
  output logic [ADDR_W-1:0]   rd_req_addr,
  output logic [TAG_W-1:0]    rd_req_tag,
  input  logic                rd_almfull,
  input  logic                rd_rsp_valid,
  input  logic [TAG_W-1:0]    rd_rsp_tag,
  input  logic [DATA_W-1:0]   rd_rsp_data,
  output logic                wr_req_valid,
  output logic [ADDR_W-1:0]   wr_req_addr,
  output logic [DATA_W-1:0]   wr_req_data,
  input  logic                wr_almfull,
  input  logic                wr_rsp_valid,
  input  logic [MC_ACK_W-1:0] wr_rsp_count
);

  localparam int CNT_W = LEN_W + 1;

  t_mc_state                state;
  logic [ADDR_W-1:0]        src_base;
  logic [ADDR_W-1:0]        dst_base;
  logic [LEN_W-1:0]         job_len;
  logic [CNT_W-1:0]         rd_issued;
  logic [CNT_W-1:0]         wr_issued;
  logic [CNT_W-1:0]         acks;
  logic [MAX_OUTSTANDING-1:0] pending;
  logic [MAX_OUTSTANDING-1:0] slot_valid;

  logic [CNT_W-1:0]         len_ext;
  logic [CNT_W-1:0]         in_flight;
  logic [TAG_W-1:0]         rd_slot;
  logic [TAG_W-1:0]         wr_slot;
  logic [CNT_W:0]           ack_sum;
  logic                     rsp_active;
  logic                     rsp_good;
  logic                     rsp_accept;
  logic                     rsp_reject;
  logic                     ack_over;
  logic                     rd_fire;
  logic                     wr_fire;
  logic                     start_go;

  assign len_ext    = {1'b0, job_len};
  assign in_flight  = rd_issued - wr_issued;
  assign rd_slot    = rd_issued[TAG_W-1:0];
  assign wr_slot    = wr_issued[TAG_W-1:0];
  assign start_go   = (state == IDLE) && start;

  // Responses count only while a job is actively moving data.
  assign rsp_active = (state == RUN) || (state == DRAIN);
  assign rsp_good   = pending[rd_rsp_tag] && !slot_valid[rd_rsp_tag];
  assign rsp_accept = rsp_active && rd_rsp_valid && rsp_good;
  assign rsp_reject = rsp_active && rd_rsp_valid && !rsp_good;

  // Read issue is limited by the slot window measured against writes
  // issued, so a slot freed this cycle is only reusable next cycle.
  assign rd_fire = (state == RUN) && (rd_issued < len_ext) &&
                   (in_flight < CNT_W'(MAX_OUTSTANDING)) && !rd_almfull;
  assign wr_fire = (state == RUN) && (wr_issued < len_ext) &&
                   slot_valid[wr_slot] && !wr_almfull;

  assign ack_sum  = {1'b0, acks} + (CNT_W + 1)'(wr_rsp_count);
  assign ack_over = ack_sum > {1'b0, len_ext};

  memcpy_slot_buf #(
    .SLOTS  (MAX_OUTSTANDING),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_slot_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (start_go),
    .set_en   (rsp_accept),
    .set_idx  (rd_rsp_tag),
    .set_data (rd_rsp_data),
    .clr_en   (wr_fire),
    .clr_idx  (wr_slot),
    .valid    (slot_valid),
    .rd_data  (wr_req_data)
  );

  // Job FSM, request issue, slot tracking, ack counting and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      src_base     <= '0;
      dst_base     <= '0;
      job_len      <= '0;
      rd_issued    <= '0;
      wr_issued    <= '0;
      acks         <= '0;
      pending      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      lines_copied <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_tag   <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
    end else begin
      rd_req_valid <= rd_fire;
      wr_req_valid <= wr_fire;
      done         <= 1'b0;

      if (rd_fire) begin
        rd_req_addr <= src_base + ADDR_W'(rd_issued);
        rd_req_tag  <= rd_slot;
        rd_issued   <= rd_issued + CNT_W'(1);
      end

      if (wr_fire) begin
        wr_req_addr <= dst_base + ADDR_W'(wr_issued);
        wr_issued   <= wr_issued + CNT_W'(1);
      end

      // A new read targets a slot that is neither pending nor valid, so it
      // never collides with the slot an accepted response retires.
      if (rsp_accept) begin
        pending[rd_rsp_tag] <= 1'b0;
      end
      if (rd_fire) begin
        pending[rd_slot] <= 1'b1;
      end

      if (rsp_reject) begin
        error <= 1'b1;
      end

      if (rsp_active && wr_rsp_valid) begin
        if (ack_over) begin
          error        <= 1'b1;
          acks         <= len_ext;
          lines_copied <= job_len;
        end else begin
          acks         <= ack_sum[CNT_W-1:0];
          lines_copied <= ack_sum[LEN_W-1:0];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            src_base     <= src_addr;
            dst_base     <= dst_addr;
            job_len      <= num_lines;
            rd_issued    <= '0;
            wr_issued    <= '0;
            acks         <= '0;
            pending      <= '0;
            error        <= 1'b0;
            lines_copied <= '0;
            if (num_lines != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (wr_issued == len_ext) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (acks == len_ext) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memcpy_engine.sv
// tb_memcpy_engine
//   Self-checking bench: a table of whole-copy jobs plus hand-written
//   multi-cycle sequences. Expected reads and writes are queued when a job
//   is started and popped as the engine emits requests.
module tb_memcpy_engine;

  localparam int ADDR_W = 42;
  localparam int DATA_W = 512;
  localparam int LEN_W  = 20;
  localparam int MAXO   = 16;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  num_lines;
  logic              busy;
  logic              done;
  logic              error;
  logic [LEN_W-1:0]  lines_copied;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]  rd_req_tag;
  logic              rd_almfull;
  logic              rd_rsp_valid;
  logic [TAG_W-1:0]  rd_rsp_tag;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic              wr_almfull;
  logic              wr_rsp_valid;
  logic [2:0]        wr_rsp_count;

  memcpy_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .num_lines(num_lines), .busy(busy), .done(done),
    .error(error), .lines_copied(lines_copied), .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag), .rd_almfull(rd_almfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid), .wr_rsp_count(wr_rsp_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rd_seen = 0, wr_seen = 0, done_cnt = 0;
  int rd_base, wr_base, done_base, acks_sent;
  bit auto_rsp = 1'b0, auto_ack = 1'b0;

  logic [ADDR_W-1:0] exp_rd_addr[$];
  logic [TAG_W-1:0]  exp_rd_tag[$];
  logic [ADDR_W-1:0] exp_wr_addr[$];
  logic [DATA_W-1:0] exp_wr_data[$];
  logic [TAG_W-1:0]  rsp_q[$];
  logic [ADDR_W-1:0] tag_addr[MAXO];

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    int                n;
    int                exp_lines;
    bit                exp_err;
  } job_t;
  job_t tbl[5];

  // Memory contents of a source line, independent of the engine.
  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    for (int j = 0; j < 16; j++) begin
      d[j*32 +: 32] = (a[31:0] * 32'h9E3779B1 + 32'(j)) ^ {22'h0, a[41:32]};
    end
    return d;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Request monitor / scoreboard, sampling on the inactive edge.
  always @(negedge clk) begin
    if (rd_req_valid) begin
      rd_seen++;
      tag_addr[rd_req_tag] = rd_req_addr;
      rsp_q.push_back(rd_req_tag);
      if (exp_rd_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected act=%0h exp=none", rd_req_addr);
      end else begin
        chk_vec("rd_addr", DATA_W'(rd_req_addr), DATA_W'(exp_rd_addr.pop_front()));
        chk_int("rd_tag", int'(rd_req_tag), int'(exp_rd_tag.pop_front()));
      end
    end
    if (wr_req_valid) begin
      wr_seen++;
      if (exp_wr_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected act=%0h exp=none", wr_req_addr);
      end else begin
        chk_vec("wr_addr", DATA_W'(wr_req_addr), DATA_W'(exp_wr_addr.pop_front()));
        chk_vec("wr_data", wr_req_data, exp_wr_data.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    logic [TAG_W-1:0] t;
    @(posedge clk);
    #1;
    start        = 1'b0;
    rd_rsp_valid = 1'b0;
    wr_rsp_valid = 1'b0;
    if (auto_rsp && rsp_q.size() > 0) begin
      t = rsp_q.pop_front();
      rd_rsp_valid = 1'b1;
      rd_rsp_tag   = t;
      rd_rsp_data  = data_of(tag_addr[t]);
    end
    if (auto_ack && wr_seen > acks_sent) begin
      wr_rsp_valid = 1'b1;
      wr_rsp_count = 3'd1;
      acks_sent++;
    end
  endtask

  task automatic send_rsp(input int t);
    rd_rsp_valid = 1'b1;
    rd_rsp_tag   = TAG_W'(t);
    rd_rsp_data  = data_of(tag_addr[t]);
    tick();
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input int n);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = s + ADDR_W'(k);
      exp_rd_addr.push_back(a);
      exp_rd_tag.push_back(TAG_W'(k));
      exp_wr_addr.push_back(d + ADDR_W'(k));
      exp_wr_data.push_back(data_of(a));
    end
    rd_base   = rd_seen;
    wr_base   = wr_seen;
    done_base = done_cnt;
    acks_sent = wr_seen;
    src_addr  = s;
    dst_addr  = d;
    num_lines = LEN_W'(n);
    start     = 1'b1;
    tick();
  endtask

  task automatic finish_job(input string name, input int n, input bit exp_err);
    for (int i = 0; i < 3000 && done_cnt == done_base; i++) tick();
    chk_int({name, "_done_seen"}, int'(done_cnt != done_base), 1);
    tick();
    tick();
    chk_int({name, "_done_pulses"}, done_cnt - done_base, 1);
    chk_int({name, "_lines_copied"}, int'(lines_copied), n);
    chk_int({name, "_error"}, int'(error), int'(exp_err));
    chk_int({name, "_busy_idle"}, int'(busy), 0);
    chk_int({name, "_reads"}, rd_seen - rd_base, n);
    chk_int({name, "_writes"}, wr_seen - wr_base, n);
    chk_int({name, "_sb_empty"}, exp_rd_addr.size() + exp_wr_addr.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; num_lines = '0;
    rd_almfull = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_tag = '0; rd_rsp_data = '0;
    wr_almfull = 1'b0; wr_rsp_valid = 1'b0; wr_rsp_count = 3'd0;
    acks_sent = 0; rd_base = 0; wr_base = 0; done_base = 0;
    for (int i = 0; i < MAXO; i++) tag_addr[i] = '0;

    tbl[0] = '{src: 42'h1000,        dst: 42'h8000,        n: 3,  exp_lines: 3,  exp_err: 1'b0};
    tbl[1] = '{src: 42'h3FF_FFFF_FFFE, dst: 42'h3FF_FFFF_FFFC, n: 6, exp_lines: 6, exp_err: 1'b0};
    tbl[2] = '{src: 42'h40,          dst: 42'h5000,        n: 17, exp_lines: 17, exp_err: 1'b0};
    tbl[3] = '{src: 42'h77,          dst: 42'h77000,       n: 1,  exp_lines: 1,  exp_err: 1'b0};
    tbl[4] = '{src: 42'h0,           dst: 42'h10,          n: 0,  exp_lines: 0,  exp_err: 1'b0};

    // Reset state
    repeat (3) tick();
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_error", int'(error), 0);
    chk_int("rst_lines", int'(lines_copied), 0);
    chk_int("rst_valids", int'({rd_req_valid, wr_req_valid}), 0);
    chk_vec("rst_rd_addr", DATA_W'(rd_req_addr), '0);
    chk_vec("rst_wr_data", wr_req_data, '0);
    reset = 1'b0;
    tick();

    // Single line, response 5 cycles after the read
    auto_rsp = 1'b0; auto_ack = 1'b0;
    start_job(42'h100, 42'h200, 1);
    chk_int("a_busy", int'(busy), 1);
    chk_int("a_rd_early", int'(rd_req_valid), 0);
    tick();
    chk_int("a_rd_latency", int'(rd_req_valid), 1);
    repeat (4) tick();
    void'(rsp_q.pop_front());
    send_rsp(0);
    auto_ack = 1'b1;
    finish_job("single", 1, 1'b0);

    // Zero-length job
    start_job(42'h100, 42'h200, 0);
    chk_int("z_done_early", int'(done), 0);
    chk_int("z_busy", int'(busy), 0);
    tick();
    chk_int("z_done_at_2", int'(done), 1);
    finish_job("zero", 0, 1'b0);

    // Outstanding window: 40 lines, responses withheld
    auto_rsp = 1'b0; auto_ack = 1'b1;
    start_job(42'h1000, 42'h3000, 40);
    repeat (30) tick();
    chk_int("b_window_reads", rd_seen - rd_base, 16);
    send_rsp(int'(rsp_q.pop_front()));
    repeat (10) tick();
    chk_int("b_one_more_read", rd_seen - rd_base, 17);
    chk_int("b_one_write", wr_seen - wr_base, 1);
    auto_rsp = 1'b1;
    finish_job("window", 40, 1'b0);

    // Reverse-order responses
    auto_rsp = 1'b0;
    start_job(42'h2000, 42'h6000, 8);
    repeat (12) tick();
    chk_int("c_reads", rd_seen - rd_base, 8);
    rsp_q.delete();
    for (int t = 7; t >= 1; t--) send_rsp(t);
    repeat (3) tick();
    chk_int("c_no_writes", wr_seen - wr_base, 0);
    send_rsp(0);
    finish_job("reverse", 8, 1'b0);

    // Back-pressure on each channel
    auto_rsp = 1'b1; auto_ack = 1'b1;
    start_job(42'h9000, 42'hA000, 24);
    repeat (3) tick();
    rd_almfull = 1'b1;
    tick();
    snap = rd_seen;
    repeat (9) tick();
    chk_int("d_rd_stalled", rd_seen - snap, 0);
    rd_almfull = 1'b0;
    repeat (3) tick();
    wr_almfull = 1'b1;
    tick();
    snap = wr_seen;
    repeat (9) tick();
    chk_int("d_wr_stalled", wr_seen - snap, 0);
    wr_almfull = 1'b0;
    finish_job("almfull", 24, 1'b0);

    // Packed acks 3 then 1
    auto_rsp = 1'b1; auto_ack = 1'b0;
    start_job(42'h300, 42'h400, 4);
    for (int i = 0; i < 50 && (wr_seen - wr_base) < 4; i++) tick();
    chk_int("e_writes", wr_seen - wr_base, 4);
    tick();
    wr_rsp_valid = 1'b1; wr_rsp_count = 3'd3;
    tick();
    repeat (3) tick();
    chk_int("e_lines_3", int'(lines_copied), 3);
    chk_int("e_busy_drain", int'(busy), 1);
    chk_int("e_no_done", done_cnt - done_base, 0);
    wr_rsp_valid = 1'b1; wr_rsp_count = 3'd1;
    finish_job("packed", 4, 1'b0);

    // Duplicate response sets sticky error
    auto_rsp = 1'b0; auto_ack = 1'b1;
    start_job(42'h500, 42'h600, 4);
    repeat (8) tick();
    rsp_q.delete();
    send_rsp(0); send_rsp(1); send_rsp(2); send_rsp(2);
    repeat (2) tick();
    chk_int("dup_error", int'(error), 1);
    send_rsp(3);
    finish_job("dup", 4, 1'b1);

    // Table of complete jobs (each start must also clear error)
    auto_rsp = 1'b1; auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_job(tbl[i].src, tbl[i].dst, tbl[i].n);
      finish_job($sformatf("tbl%0d", i), tbl[i].exp_lines, tbl[i].exp_err);
    end

    // Reset in the middle of a 20-line job, late responses afterwards
    auto_rsp = 1'b0; auto_ack = 1'b0;
    start_job(42'h700, 42'h800, 20);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_int("g_busy", int'(busy), 0);
    chk_int("g_rd_valid", int'(rd_req_valid), 0);
    exp_rd_addr.delete(); exp_rd_tag.delete();
    exp_wr_addr.delete(); exp_wr_data.delete();
    rsp_q.delete();
    rd_base = rd_seen; wr_base = wr_seen; done_base = done_cnt;
    for (int t = 0; t < 4; t++) send_rsp(t);
    repeat (3) tick();
    chk_int("g_error", int'(error), 0);
    chk_int("g_reads", rd_seen - rd_base, 0);
    chk_int("g_writes", wr_seen - wr_base, 0);
    chk_int("g_done", done_cnt - done_base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
